// File: rtl/jtag_pkg.sv
// Purpose: shared JTAG definitions for the TAP controller and the downstream
//          boundary_scan_chain: TAP state encoding, opcodes, control bus bits.
// Ports:   none (package).
package jtag_pkg;

    localparam int unsigned STATE_WIDTH  = 4;
    localparam int unsigned CTL_WIDTH    = 4;
    localparam int unsigned OP_WIDTH     = 4;
    localparam int unsigned IDCODE_WIDTH = 32;

    // Standard 1149.1 state encoding so tap_state matches common debug tools.
    typedef enum logic [STATE_WIDTH-1:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [OP_WIDTH-1:0] OP_EXTEST         = 4'h0;
    localparam logic [OP_WIDTH-1:0] OP_SAMPLE_PRELOAD = 4'h1;
    localparam logic [OP_WIDTH-1:0] OP_IDCODE         = 4'h2;
    localparam logic [OP_WIDTH-1:0] OP_BYPASS         = 4'hF;

    // Bit positions on the control bus to boundary_scan_chain.
    localparam int unsigned CTL_SHIFT   = 0;
    localparam int unsigned CTL_UPDATE  = 1;
    localparam int unsigned CTL_CAPTURE = 2;
    localparam int unsigned CTL_MODE    = 3;

endpackage

// File: rtl/jtag_tap_controller_fsm.sv
// Purpose: 16-state IEEE 1149.1 TAP state machine (state register + next state).
// Ports:   tck/trst clock and async active-high reset; tms mode select;
//          state current state; state_next combinational next state.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state,
    output tap_state_e state_next
);

    // State register.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            TLR:    state_next = tms ? TLR    : RTI;
            RTI:    state_next = tms ? SEL_DR : RTI;
            SEL_DR: state_next = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_next = tms ? EX1_DR : SH_DR;
            SH_DR:  state_next = tms ? EX1_DR : SH_DR;
            EX1_DR: state_next = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_next = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_next = tms ? UPD_DR : SH_DR;
            UPD_DR: state_next = tms ? SEL_DR : RTI;
            SEL_IR: state_next = tms ? TLR    : CAP_IR;
            CAP_IR: state_next = tms ? EX1_IR : SH_IR;
            SH_IR:  state_next = tms ? EX1_IR : SH_IR;
            EX1_IR: state_next = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_next = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_next = tms ? UPD_IR : SH_IR;
            UPD_IR: state_next = tms ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// Purpose: JTAG TAP controller: instruction register, bypass and IDCODE data
//          registers, boundary-chain control decode and TDO mux.
// Ports:   tck, trst      clock, async active-high reset
//          tms, tdi       JTAG mode select and serial data in
//          bsc_tdo        serial out of the downstream boundary chain
//          control[3:0]   {mode, capture, update, shift} to the boundary chain
//          tdo, tdo_en    device serial out (negedge registered) and its enable
//          ir_out         latched instruction
//          tap_state      current TAP state encoding
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1A5C_3E01
) (
    input  logic                 tck,
    input  logic                 trst,
    input  logic                 tms,
    input  logic                 tdi,
    input  logic                 bsc_tdo,
    output logic [CTL_WIDTH-1:0] control,
    output logic                 tdo,
    output logic                 tdo_en,
    output logic [IR_WIDTH-1:0]  ir_out,
    output logic [3:0]           tap_state
);

    tap_state_e                  state;
    tap_state_e                  state_next;
    logic [IR_WIDTH-1:0]         ir_shift;
    logic [IR_WIDTH-1:0]         ir_latch;
    logic                        bypass_reg;
    logic [IDCODE_WIDTH-1:0]     idcode_sr;
    logic                        sel_boundary;
    logic                        sel_idcode;
    logic                        sel_bypass;
    logic                        dr_bit;

    tap_fsm u_fsm (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .state      (state),
        .state_next (state_next)
    );

    // Instruction decode; unknown opcodes fall back to bypass.
    always_comb begin
        sel_boundary = (ir_latch == IR_WIDTH'(OP_EXTEST)) ||
                       (ir_latch == IR_WIDTH'(OP_SAMPLE_PRELOAD));
        sel_idcode   = (ir_latch == IR_WIDTH'(OP_IDCODE));
        sel_bypass   = !sel_boundary && !sel_idcode;
    end

    // Instruction register: capture/shift path plus the latched instruction.
    // The latch reloads IDCODE on any edge that lands in TLR, so a TMS reset
    // behaves like trst for the instruction.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_shift <= '0;
            ir_latch <= IR_WIDTH'(OP_IDCODE);
        end else begin
            case (state)
                CAP_IR:  ir_shift <= IR_WIDTH'(2'b01);
                SH_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                default: ir_shift <= ir_shift;
            endcase
            if (state_next == TLR) begin
                ir_latch <= IR_WIDTH'(OP_IDCODE);
            end else if (state == UPD_IR) begin
                ir_latch <= ir_shift;
            end
        end
    end

    // Bypass and IDCODE data registers; only the selected one moves.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            bypass_reg <= 1'b0;
            idcode_sr  <= '0;
        end else begin
            if (state == CAP_DR) begin
                if (sel_bypass) bypass_reg <= 1'b0;
                if (sel_idcode) idcode_sr  <= IDCODE_VAL;
            end else if (state == SH_DR) begin
                if (sel_bypass) bypass_reg <= tdi;
                if (sel_idcode) idcode_sr  <= {tdi, idcode_sr[IDCODE_WIDTH-1:1]};
            end
        end
    end

    // Boundary chain control, decoded from the current state so the chain sees
    // it ahead of the posedge on which it acts.
    always_comb begin
        control                = '0;
        control[CTL_MODE]      = (ir_latch == IR_WIDTH'(OP_EXTEST));
        if (sel_boundary) begin
            control[CTL_CAPTURE] = (state == CAP_DR);
            control[CTL_SHIFT]   = (state == SH_DR);
            control[CTL_UPDATE]  = (state == UPD_DR);
        end
    end

    // Selected data register serial bit.
    always_comb begin
        if (sel_boundary) begin
            dr_bit = bsc_tdo;
        end else if (sel_idcode) begin
            dr_bit = idcode_sr[0];
        end else begin
            dr_bit = bypass_reg;
        end
    end

    // TDO launched on the falling edge so it is stable at the next rising edge.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
            case (state)
                SH_IR: begin
                    tdo    <= ir_shift[0];
                    tdo_en <= 1'b1;
                end
                SH_DR: begin
                    tdo    <= dr_bit;
                    tdo_en <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ir_out    = ir_latch;
    assign tap_state = state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Purpose: self-checking bench for jtag_tap_controller. Stimulus queues the
//          expected TDO bits; a monitor pops one per enabled TDO cycle.
// Ports:   none (top-level bench).
module tb_jtag_tap_controller;
    import jtag_pkg::*;

    logic       tck = 1'b0;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       bsc_tdo;
    logic [3:0] control;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir_out;
    logic [3:0] tap_state;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_q[$];
    logic mon_exp;
    bit   mon_on = 1'b0;

    localparam logic [31:0] IDCODE_EXP = 32'h1A5C_3E01;
    localparam logic [5:0]  BSC_PAT    = 6'b101101;
    localparam logic [5:0]  BYP_PAT    = 6'b110101;

    jtag_tap_controller #(
        .IR_WIDTH   (4),
        .IDCODE_VAL (32'h1A5C_3E01)
    ) dut (
        .tck       (tck),
        .trst      (trst),
        .tms       (tms),
        .tdi       (tdi),
        .bsc_tdo   (bsc_tdo),
        .control   (control),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .ir_out    (ir_out),
        .tap_state (tap_state)
    );

    always #5 tck = ~tck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One TCK cycle: drive tms/tdi, return 1 time unit after the rising edge.
    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    // IR scan from RTI back to RTI, loading op; captured pattern 4'b0001 shifts out.
    task automatic ir_scan(input logic [3:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(i == 0);
            step(i == 3, op[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // TDO monitor: every enabled cycle consumes one expected bit; idle tdo must be 0.
    always @(posedge tck) begin
        if (mon_on) begin
            if (tdo_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tdo_unexpected: tdo=%b with no expected bit queued at %0t", tdo, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("tdo_bit", 32'(tdo), 32'(mon_exp));
                end
            end else begin
                chk("tdo_idle", 32'(tdo), 32'd0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        trst    = 1'b0;
        tms     = 1'b1;
        tdi     = 1'b0;
        bsc_tdo = 1'b0;

        // Reset asserted mid-cycle takes effect immediately.
        #3 trst = 1'b1;
        #1;
        chk("rst_state",   32'(tap_state), 32'(TLR));
        chk("rst_ir",      32'(ir_out),    32'h2);
        chk("rst_control", 32'(control),   32'h0);
        chk("rst_tdo_en",  32'(tdo_en),    32'h0);
        @(posedge tck);
        #1;
        trst   = 1'b0;
        mon_on = 1'b1;
        step(1'b1, 1'b0);
        chk("tlr_hold", 32'(tap_state), 32'(TLR));

        // IDCODE read: full 32-bit stream, last bit exits with tms=1.
        step(1'b0, 1'b0);
        chk("rti", 32'(tap_state), 32'(RTI));
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("idc_cap_control", 32'(control), 32'h0);
        step(1'b0, 1'b0);
        chk("idc_sh_dr", 32'(tap_state), 32'(SH_DR));
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(IDCODE_EXP[i]);
            step(i == 31, 1'b0);
        end
        chk("idc_ex1", 32'(tap_state), 32'(EX1_DR));
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // IDCODE read interrupted by a 10-cycle pause.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(IDCODE_EXP[i]);
            step(i == 9, 1'b0);
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("pause_state", 32'(tap_state), 32'(PAU_DR));
        step(1'b1, 1'b0);
        chk("ex2_state", 32'(tap_state), 32'(EX2_DR));
        step(1'b0, 1'b0);
        for (int i = 10; i < 32; i++) begin
            exp_q.push_back(IDCODE_EXP[i]);
            step(i == 31, 1'b0);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // EXTEST load and a boundary DR scan.
        ir_scan(4'h0);
        chk("extest_ir",      32'(ir_out),  32'h0);
        chk("extest_control", 32'(control), 32'h8);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("extest_capture", 32'(control), 32'hC);
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("extest_shift", 32'(control), 32'h9);
            bsc_tdo = BSC_PAT[i];
            exp_q.push_back(BSC_PAT[i]);
            step(i == 5, 1'b0);
        end
        bsc_tdo = 1'b0;
        chk("extest_ex1",    32'(control), 32'h8);
        step(1'b1, 1'b0);
        chk("extest_update", 32'(control), 32'hA);
        step(1'b0, 1'b0);
        chk("extest_rti",    32'(control), 32'h8);

        // Unknown opcode 4'h7 behaves as BYPASS: one-cycle tdi->tdo delay.
        ir_scan(4'h7);
        chk("byp_ir",      32'(ir_out),  32'h7);
        chk("byp_control", 32'(control), 32'h0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("byp_capture", 32'(control), 32'h0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("byp_shift", 32'(control), 32'h0);
            exp_q.push_back((i == 0) ? 1'b0 : BYP_PAT[i-1]);
            step(i == 5, BYP_PAT[i]);
        end
        step(1'b1, 1'b0);
        chk("byp_update", 32'(control), 32'h0);
        step(1'b0, 1'b0);

        // Five tms=1 edges from SH_DR reach TLR and reload IDCODE.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("tmsrst_sh", 32'(tap_state), 32'(SH_DR));
        exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("tmsrst_sel_ir", 32'(tap_state), 32'(SEL_IR));
        chk("tmsrst_ir_kept", 32'(ir_out),   32'h7);
        step(1'b1, 1'b0);
        chk("tmsrst_state", 32'(tap_state), 32'(TLR));
        chk("tmsrst_ir",    32'(ir_out),    32'h2);

        // trst in the middle of an IR shift.
        step(1'b0, 1'b0);
        ir_scan(4'h0);
        chk("pre_rst_ir", 32'(ir_out), 32'h0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        exp_q.push_back(1'b1);
        step(1'b0, 1'b1);
        #2 trst = 1'b1;
        #1;
        chk("mid_rst_state",   32'(tap_state), 32'(TLR));
        chk("mid_rst_ir",      32'(ir_out),    32'h2);
        chk("mid_rst_control", 32'(control),   32'h0);
        chk("mid_rst_tdo_en",  32'(tdo_en),    32'h0);
        chk("mid_rst_tdo",     32'(tdo),       32'h0);
        @(negedge tck);
        #1;
        trst = 1'b0;
        step(1'b1, 1'b0);
        chk("post_rst_state", 32'(tap_state), 32'(TLR));
        chk("post_rst_ir",    32'(ir_out),    32'h2);
        step(1'b1, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- IEEE 1149.1 TAP controller and instruction register; sits directly upstream of boundary_scan_chain.
- Decodes TMS on tck into the chain's 4-bit control bus.
- Owns the bypass and IDCODE data registers.
- Muxes the selected serial register onto the device TDO.

Parameters:
- IR_WIDTH, 4, instruction register width in bits.
- IDCODE_VAL, 32'h1A5C_3E01, device identification value; bit 0 must be 1.

Ports:
- tck  input  1  JTAG test clock, the single clock.
- trst  input  1  reset, asynchronous, active-high.
- tms  input  1  test mode select, sampled on posedge tck.
- tdi  input  1  serial data in; feeds IR, bypass and IDCODE shift paths.
- bsc_tdo  input  1  serial out of the downstream boundary_scan_chain.
- control  output  4  boundary chain control: [0] shift, [1] update, [2] capture, [3] mode (EXTEST).
- tdo  output  1  device serial out.
- tdo_en  output  1  high while tdo is valid (Shift-IR / Shift-DR).
- ir_out  output  IR_WIDTH  current latched instruction, for debug and the 1687 network.
- tap_state  output  4  current FSM state encoding.

Behaviour:
- Clock and reset:
  - One clock, tck. Reset is asynchronous and active-high on trst.
- State machine:
  - 16-state standard TAP FSM on posedge tck.
  - States: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
  - Transitions per 1149.1 (e.g. TLR: tms=0 goes to RTI; SEL_IR with tms=1 goes to TLR).
  - Five consecutive tms=1 edges reach TLR from any state.
  - Entering TLR by TMS also loads IR with IDCODE.
- Reset values:
  - State TLR; IR latch IDCODE (4'h2); IR shift register 0.
  - Bypass 0; IDCODE shift register 0.
  - tdo 0, tdo_en 0, control 0.
- Reset mid-operation:
  - Asserting trst in any state, including mid-shift, forces these values immediately.
  - Shifted data is discarded; the IR latch does not update.
- Opcodes:
  - EXTEST 4'h0, SAMPLE_PRELOAD 4'h1, IDCODE 4'h2, BYPASS 4'hF.
  - Any other opcode decodes as BYPASS.
- Instruction register:
  - CAP_IR loads the shift register with {0..0,2'b01}.
  - SH_IR shifts right: tdi enters the MSB, the LSB goes to tdo.
  - UPD_IR copies the shift register into the IR latch. The latch changes only in UPD_IR or TLR.
- Data registers, selected by the IR latch:
  - Bypass: 1 bit. Captures 0 in CAP_DR; in SH_DR it loads tdi.
  - IDCODE: 32 bits. Captures IDCODE_VAL in CAP_DR; shifts right in SH_DR.
  - Boundary (EXTEST or SAMPLE_PRELOAD): owned downstream.
- control outputs:
  - Moore-decoded from the state register, so they are valid for the same posedge at which the chain acts.
  - control[2] = CAP_DR and boundary selected.
  - control[0] = SH_DR and boundary selected.
  - control[1] = UPD_DR and boundary selected.
  - control[3] = IR latch equals EXTEST, in all states.
  - With a non-boundary instruction, control[2:0] stay 0.
- TDO:
  - Registered on negedge tck.
  - In SH_IR: IR shift LSB. In SH_DR: LSB of the selected DR (bsc_tdo for boundary).
  - tdo_en is registered with tdo. tdo holds 0 when tdo_en=0.
- Pause states hold all shift registers unchanged.

Decomposition:
- Package jtag_pkg:
  - tap_state_e enum, 4-bit encoding.
  - Opcode localparams.
  - Control bit index constants (CTL_SHIFT=0, CTL_UPDATE=1, CTL_CAPTURE=2, CTL_MODE=3), shared with boundary_scan_chain.
- Sub-module tap_fsm: pure next-state logic plus state register.
- jtag_tap_controller owns the IR, bypass, IDCODE, control decode and TDO mux.

Test Plan:
- Reset: pulse trst mid-cycle -> immediately tap_state=TLR, ir_out=4'h2, control=4'b0000, tdo_en=0.
- IDCODE read: TMS 0,1,0,0 then 32 shifts with the last at tms=1 -> tdo bit stream LSB-first equals 32'h1A5C_3E01. The first bit is 1.
- IR scan EXTEST: reach SH_IR and shift tdi 0,0,0,0 (last with tms=1); first two tdo bits are 1,0; exit through UPD_IR.
  - Response: ir_out=4'h0, control[3]=1.
  - Then a DR scan pulses control[2] for one cycle, holds control[0] for N shift cycles, pulses control[1] for one cycle, and tdo follows bsc_tdo.
- BYPASS and unknown opcode: load 4'h7 -> DR scan shows a one-cycle delay tdi->tdo; the first bit out is 0; control[2:0] stay 0.
- TMS reset: from SH_DR apply five tms=1 edges -> tap_state=TLR, ir_out=4'h2 without trst.
- Pause: SH_DR -> EX1_DR -> PAU_DR held 10 cycles -> EX2_DR -> SH_DR. The IDCODE bit stream continues with no lost or duplicated bits.
